// File: rtl/id_ex_stage_if.sv
// Decode-to-ALU bus of the ID/EX stage: the upstream valid/ready handshake with
// its instruction fields, plus the downstream ALU operands and handshake.
interface id_ex_stage_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
);
  // Upstream side (decode -> ID/EX)
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [REG_AW-1:0] rd_addr;
  logic [XLEN-1:0]   imm;
  logic              alu_src;
  logic [1:0]        alu_op;
  logic [2:0]        funct3;
  logic              funct7_5;
  logic              is_rtype;
  logic              reg_write;
  logic              flush;

  // Downstream side (ID/EX -> ALU / EX)
  logic              out_ready;
  logic              out_valid;
  logic [XLEN-1:0]   alu_a;
  logic [XLEN-1:0]   alu_b;
  logic [3:0]        alu_ctrl;
  logic [XLEN-1:0]   store_data;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              illegal;

  // Environment view: drives instructions and consumes ALU operands
  modport master (
    output in_valid, rs1_data, rs2_data, rs1_addr, rs2_addr, rd_addr, imm,
           alu_src, alu_op, funct3, funct7_5, is_rtype, reg_write, flush,
           out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_ctrl, store_data, ex_rd,
           ex_reg_write, illegal
  );

  // Stage view
  modport slave (
    input  in_valid, rs1_data, rs2_data, rs1_addr, rs2_addr, rd_addr, imm,
           alu_src, alu_op, funct3, funct7_5, is_rtype, reg_write, flush,
           out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_ctrl, store_data, ex_rd,
           ex_reg_write, illegal
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: holds decoded fields, decodes ALUCtrl, and resolves
// EX/MEM and MEM/WB forwarding combinationally on the held source indices.
module id_ex_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  id_ex_stage_if.slave      bus,
  input  logic              exmem_reg_write,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic [XLEN-1:0]   memwb_result
);

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_ctrl_e;

  logic              valid_q;
  logic [XLEN-1:0]   rs1_data_q;
  logic [XLEN-1:0]   rs2_data_q;
  logic [REG_AW-1:0] rs1_addr_q;
  logic [REG_AW-1:0] rs2_addr_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   imm_q;
  logic              alu_src_q;
  logic [1:0]        alu_op_q;
  logic [2:0]        funct3_q;
  logic              funct7_5_q;
  logic              is_rtype_q;
  logic              reg_write_q;

  logic              capture;
  alu_ctrl_e         ctrl;
  logic              bad_funct;
  logic [XLEN-1:0]   fwd_rs1;
  logic [XLEN-1:0]   fwd_rs2;

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign capture      = bus.in_valid && bus.in_ready && !bus.flush;

  // Pipeline register: flush beats capture beats drain; otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      alu_op_q    <= '0;
      funct3_q    <= '0;
      funct7_5_q  <= 1'b0;
      is_rtype_q  <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q     <= 1'b1;
      rs1_data_q  <= bus.rs1_data;
      rs2_data_q  <= bus.rs2_data;
      rs1_addr_q  <= bus.rs1_addr;
      rs2_addr_q  <= bus.rs2_addr;
      rd_q        <= bus.rd_addr;
      imm_q       <= bus.imm;
      alu_src_q   <= bus.alu_src;
      alu_op_q    <= bus.alu_op;
      funct3_q    <= bus.funct3;
      funct7_5_q  <= bus.funct7_5;
      is_rtype_q  <= bus.is_rtype;
      reg_write_q <= bus.reg_write;
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // ALUCtrl decode from the held ALUOp/funct fields
  always_comb begin
    ctrl      = ALU_ADD;
    bad_funct = 1'b0;
    case (alu_op_q)
      2'b01: ctrl = ALU_SUB;
      2'b10: begin
        case (funct3_q)
          3'b000:  ctrl = (is_rtype_q && funct7_5_q) ? ALU_SUB : ALU_ADD;
          3'b111:  ctrl = ALU_AND;
          3'b110:  ctrl = ALU_OR;
          3'b010:  ctrl = ALU_SLT;
          default: bad_funct = 1'b1;
        endcase
      end
      default: ctrl = ALU_ADD;
    endcase
  end

  // Operand forwarding: EX/MEM wins over MEM/WB, x0 is never forwarded
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs1_addr_q))
      fwd_rs1 = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs1_addr_q))
      fwd_rs1 = memwb_result;

    fwd_rs2 = rs2_data_q;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs2_addr_q))
      fwd_rs2 = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs2_addr_q))
      fwd_rs2 = memwb_result;
  end

  assign bus.out_valid    = valid_q;
  assign bus.alu_ctrl     = ctrl;
  assign bus.alu_a        = fwd_rs1;
  assign bus.alu_b        = alu_src_q ? imm_q : fwd_rs2;
  assign bus.store_data   = fwd_rs2;
  assign bus.ex_rd        = rd_q;
  assign bus.ex_reg_write = valid_q && reg_write_q;
  assign bus.illegal      = valid_q && bad_funct;

endmodule
